mem_port_arbiter: RTL and testbench

//   Shares the single memory port between the instruction fetch unit (master 0, IFU)
//   and the load/store path (master 1, LSU) of the RV32 core.
//   It sequences one transaction at a time: request, memory accept, memory response,

---
 rtl/mem_port_arbiter_if.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundle of every handshake/bus signal around the memory port arbiter:
//   the IFU request/response channel, the LSU request/response channel and
//   the single shared memory port.
//
//   Modports
//     slave  : arbiter view (consumes IFU/LSU requests and memory answers,
//              produces readies, responses and the memory request)
//     master : environment view (IFU, LSU and the memory model)
//
//   Handshake rules (all channels):
//     A request is transferred on a rising clk edge where valid and ready are
//     both 1. The requester holds valid and its payload stable until that
//     edge. Response valids (ifu/lsu_resp_valid) are single-cycle pulses with
//     no back-pressure; mem_resp_valid is likewise a one-cycle pulse from the
//     memory and is only consumed while a transaction is outstanding.
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // IFU channel
  logic                    ifu_req_valid;
  logic                    ifu_req_ready;
  logic [ADDR_WIDTH-1:0]   ifu_addr;
  logic                    ifu_resp_valid;
  logic [DATA_WIDTH-1:0]   ifu_rdata;
  logic                    ifu_resp_err;

  // LSU channel
  logic                    lsu_req_valid;
  logic                    lsu_req_ready;
  logic [ADDR_WIDTH-1:0]   lsu_addr;
  logic                    lsu_wen;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic [DATA_WIDTH/8-1:0] lsu_wmask;
  logic                    lsu_resp_valid;
  logic [DATA_WIDTH-1:0]   lsu_rdata;
  logic                    lsu_resp_err;

  // Shared memory port
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_wen;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wmask;
  logic                    mem_resp_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single memory port between the instruction fetch unit
//   (master 0, IFU) and the load/store path (master 1, LSU). One transaction
//   is in flight at a time: grant, memory request, memory response, return of
//   the response to the owning master. A watchdog turns a memory that never
//   answers into an error response.
//
//   Parameters
//     DATA_WIDTH  data bus width
//     ADDR_WIDTH  address width
//     TIMEOUT     cycles allowed in WAIT before an error response (0 = off)
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   asynchronous reset, active high
//     bus      if   mem_port_arbiter_if.slave (IFU, LSU and memory channels)
//     state_o  out  current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RESP)
//
//   Build option
//     ARB_ROUND_ROBIN_EN  defined: on a tie the master not granted last wins
//                         (last grant resets to IFU, so LSU wins the first
//                         tie). Undefined: LSU always wins a tie.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        state_o
);

  localparam int MW   = DATA_WIDTH / 8;
  // Watchdog counts 0 .. TIMEOUT-1 inside WAIT.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    owner_q;     // 0 = IFU, 1 = LSU; doubles as last grant
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [MW-1:0]           wmask_q;
  logic                    mem_req_valid_q;
  logic [WD_W-1:0]         wd_q;

  logic                    ifu_resp_valid_q;
  logic [DATA_WIDTH-1:0]   ifu_rdata_q;
  logic                    ifu_err_q;
  logic                    lsu_resp_valid_q;
  logic [DATA_WIDTH-1:0]   lsu_rdata_q;
  logic                    lsu_err_q;

  // Next-cycle response (entering RESP) computed from the current state.
  logic                    rsp_fire_d;
  logic                    rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_data_d;

  logic                    idle;
  logic                    any_req;
  logic                    lsu_wins_tie;
  logic                    grant_lsu;
  logic                    wd_expired;
  logic [DATA_WIDTH-1:0]   mem_rdata_eff;

  // --------------------------------------------------------------------------
  // Arbitration (combinational, only meaningful in IDLE)
  // --------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  assign lsu_wins_tie = (owner_q == 1'b0);
`else
  assign lsu_wins_tie = 1'b1;
`endif

  // Readies are forced low during reset even though state_q reads IDLE.
  assign idle      = (state_q == S_IDLE) && !rst;
  assign any_req   = bus.ifu_req_valid || bus.lsu_req_valid;
  assign grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || lsu_wins_tie);

  assign bus.ifu_req_ready = idle && bus.ifu_req_valid && !grant_lsu;
  assign bus.lsu_req_ready = idle && grant_lsu;

  // --------------------------------------------------------------------------
  // Response selection
  // --------------------------------------------------------------------------
  // Stores return zero data; IFU transactions always have wen_q = 0.
  assign mem_rdata_eff = wen_q ? '0 : bus.mem_rdata;
  assign wd_expired    = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    rsp_fire_d = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;
    case (state_q)
      S_REQ: begin
        // Memory may accept and answer in the same cycle.
        if (bus.mem_req_ready && bus.mem_resp_valid) begin
          rsp_fire_d = 1'b1;
          rsp_data_d = mem_rdata_eff;
        end
      end
      S_WAIT: begin
        // A real answer wins over the watchdog in the same cycle.
        if (bus.mem_resp_valid) begin
          rsp_fire_d = 1'b1;
          rsp_data_d = mem_rdata_eff;
        end else if (wd_expired) begin
          rsp_fire_d = 1'b1;
          rsp_err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      owner_q          <= 1'b0;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      mem_req_valid_q  <= 1'b0;
      wd_q             <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      ifu_err_q        <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= '0;
      lsu_err_q        <= 1'b0;
    end else begin
      // Response outputs are one-cycle pulses; data/err read 0 otherwise.
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      ifu_err_q        <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= '0;
      lsu_err_q        <= 1'b0;

      if (rsp_fire_d) begin
        if (owner_q) begin
          lsu_resp_valid_q <= 1'b1;
          lsu_rdata_q      <= rsp_data_d;
          lsu_err_q        <= rsp_err_d;
        end else begin
          ifu_resp_valid_q <= 1'b1;
          ifu_rdata_q      <= rsp_data_d;
          ifu_err_q        <= rsp_err_d;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q         <= grant_lsu;
            addr_q          <= grant_lsu ? bus.lsu_addr : bus.ifu_addr;
            wen_q           <= grant_lsu && bus.lsu_wen;
            wdata_q         <= grant_lsu ? bus.lsu_wdata : '0;
            wmask_q         <= grant_lsu ? bus.lsu_wmask : '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= rsp_fire_d ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_fire_d) begin
            state_q <= S_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP: begin
          wd_q    <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.ifu_resp_err   = ifu_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_err_q;

  assign state_o            = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter (TIMEOUT = 8). A driver task acts
//   as IFU, LSU and memory for one round of one or two requests and records
//   what it observes; scenario tasks compare the observations against a
//   reference model of the arbitration rule and of the transaction timing.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [1:0] dbg_state;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];   // {who, err, rdata} per expected response
  bit m_last = 1'b0;       // model: last granted master (0 IFU, 1 LSU)

  // Winner of the first grant given which masters are requesting.
  function automatic bit model_first(input bit ri, input bit rl);
    if (ri && rl) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !m_last;
`else
      return 1'b1;
`endif
    end
    return rl;
  endfunction

  // ---------------- observations from the driver ----------------
  logic [1:0]  o_gnt[2];
  bit          o_who[2];
  logic [31:0] o_rdata[2];
  bit          o_err[2];
  int          o_lat[2];
  logic [31:0] o_addr[2];
  bit          o_wen[2];
  logic [31:0] o_wdata[2];
  logic [3:0]  o_wmask[2];
  bit          o_stable[2];
  bit          o_leak[2];
  bit          o_pulse2[2];
  bit          o_both[2];
  bit          o_hang[2];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_last = 1'b0;
    exp_q.delete();
  endtask

  // One round: the selected masters request together; the memory accepts
  // after 'acc' cycles of mem_req_valid and answers 'rsp' cycles after the
  // accept (0 = same cycle), or never when 'mute' is set.
  task automatic run_round(input bit ri, input bit rl,
                           input logic [31:0] iaddr, input logic [31:0] laddr,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           input bit wen, input int acc, input int rsp,
                           input bit mute, input logic [31:0] rd0,
                           input logic [31:0] rd1);
    int  n;
    int  gcyc;
    int  acc_cyc;
    int  req_seen;
    bit  done;
    bit  cur;
    logic [31:0] rd;
    @(negedge clk);
    bus.ifu_req_valid = ri;
    bus.ifu_addr      = iaddr;
    bus.lsu_req_valid = rl;
    bus.lsu_addr      = laddr;
    bus.lsu_wen       = wen;
    bus.lsu_wdata     = wdata;
    bus.lsu_wmask     = wmask;
    n = int'(ri) + int'(rl);
    for (int g = 0; g < 2; g++) begin
      o_hang[g] = 1'b0; o_stable[g] = 1'b1; o_leak[g] = 1'b0;
      o_pulse2[g] = 1'b0; o_both[g] = 1'b0;
    end
    for (int g = 0; g < n; g++) begin
      #1;
      o_gnt[g] = {bus.lsu_req_ready, bus.ifu_req_ready};
      gcyc = cyc;
      cur  = bus.lsu_req_ready;
      if (!bus.lsu_req_ready && !bus.ifu_req_ready) begin
        o_hang[g] = 1'b1;
        break;
      end
      @(negedge clk);
      if (cur) bus.lsu_req_valid = 1'b0;
      else     bus.ifu_req_valid = 1'b0;
      rd       = (g == 0) ? rd0 : rd1;
      req_seen = 0;
      acc_cyc  = -1;
      done     = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
          done       = 1'b1;
          o_who[g]   = bus.lsu_resp_valid;
          o_both[g]  = bus.lsu_resp_valid && bus.ifu_resp_valid;
          o_rdata[g] = bus.lsu_resp_valid ? bus.lsu_rdata : bus.ifu_rdata;
          o_err[g]   = bus.lsu_resp_valid ? bus.lsu_resp_err : bus.ifu_resp_err;
          o_lat[g]   = cyc - gcyc;
          o_leak[g]  = bus.ifu_req_ready || bus.lsu_req_ready;
          bus.mem_req_ready  = 1'b0;
          bus.mem_resp_valid = 1'b0;
        end else begin
          bus.mem_req_ready = 1'b0;
          if (bus.mem_req_valid) begin
            if (req_seen == 0) begin
              o_addr[g] = bus.mem_addr; o_wen[g] = bus.mem_wen;
              o_wdata[g] = bus.mem_wdata; o_wmask[g] = bus.mem_wmask;
            end else if (o_addr[g] !== bus.mem_addr || o_wen[g] !== bus.mem_wen ||
                         o_wdata[g] !== bus.mem_wdata || o_wmask[g] !== bus.mem_wmask) begin
              o_stable[g] = 1'b0;
            end
            req_seen++;
            if (req_seen > acc) begin
              bus.mem_req_ready = 1'b1;
              acc_cyc = cyc;
            end
          end
          bus.mem_resp_valid = !mute && acc_cyc >= 0 && (cyc - acc_cyc) == rsp;
          bus.mem_rdata      = bus.mem_resp_valid ? rd : $urandom;
          @(negedge clk);
        end
      end
      if (!done) begin
        o_hang[g] = 1'b1;
        break;
      end
      @(negedge clk);
      o_pulse2[g] = bus.ifu_resp_valid || bus.lsu_resp_valid;
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ifu_req_valid  = 1'b1;
    bus.lsu_req_valid  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hFFFF_FFFF;
    #1;
    total++; if (bus.ifu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ifu_ready got %b want 0", bus.ifu_req_ready); end
    total++; if (bus.lsu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_lsu_ready got %b want 0", bus.lsu_req_ready); end
    total++; if (bus.ifu_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_ifu_resp got %b want 0", bus.ifu_resp_valid); end
    total++; if (bus.lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_lsu_resp got %b want 0", bus.lsu_resp_valid); end
    total++; if ({bus.ifu_resp_err, bus.lsu_resp_err} !== 2'b00) begin bad++; $display("FAIL rst_err got %b want 00", {bus.ifu_resp_err, bus.lsu_resp_err}); end
    total++; if (bus.ifu_rdata !== 32'h0) begin bad++; $display("FAIL rst_ifu_rdata got %h want 0", bus.ifu_rdata); end
    total++; if (bus.lsu_rdata !== 32'h0) begin bad++; $display("FAIL rst_lsu_rdata got %h want 0", bus.lsu_rdata); end
    total++; if (bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got %b want 0", bus.mem_req_valid); end
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen} !== 69'h0) begin bad++; $display("FAIL rst_mem_fields got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got %0d want 0 (IDLE)", dbg_state); end
    idle_inputs();
    @(negedge clk);
    rst    = 1'b0;
    m_last = 1'b0;
  endtask

  task automatic test_ifu_fetch();
    run_round(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 4'h0, 1'b0, 0, 1, 1'b0,
              32'h0010_0073, 32'h0);
    m_last = 1'b0;
    total++; if (o_hang[0] !== 1'b0) begin bad++; $display("FAIL fetch_hang got %b want 0", o_hang[0]); end
    total++; if (o_gnt[0] !== 2'b01) begin bad++; $display("FAIL fetch_gnt got %b want 01", o_gnt[0]); end
    total++; if (o_lat[0] !== 3) begin bad++; $display("FAIL fetch_lat got %0d want 3", o_lat[0]); end
    total++; if (o_who[0] !== 1'b0 || o_both[0] !== 1'b0) begin bad++; $display("FAIL fetch_owner got lsu=%b both=%b want 0 0", o_who[0], o_both[0]); end
    total++; if (o_rdata[0] !== 32'h0010_0073) begin bad++; $display("FAIL fetch_rdata got %h want 00100073", o_rdata[0]); end
    total++; if (o_err[0] !== 1'b0) begin bad++; $display("FAIL fetch_err got %b want 0", o_err[0]); end
    total++; if (o_pulse2[0] !== 1'b0) begin bad++; $display("FAIL fetch_pulse got %b want 0", o_pulse2[0]); end
    total++; if ({o_addr[0], o_wen[0], o_wmask[0]} !== {32'h8000_0000, 1'b0, 4'h0}) begin bad++; $display("FAIL fetch_mem got %h/%b/%b want 80000000/0/0000", o_addr[0], o_wen[0], o_wmask[0]); end
  endtask

  task automatic test_store();
    run_round(1'b0, 1'b1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1, 2,
              1'b0, 32'h1234_5678, 32'h0);
    m_last = 1'b1;
    total++; if (o_hang[0] !== 1'b0) begin bad++; $display("FAIL store_hang got %b want 0", o_hang[0]); end
    total++; if (o_gnt[0] !== 2'b10) begin bad++; $display("FAIL store_gnt got %b want 10", o_gnt[0]); end
    total++; if (o_who[0] !== 1'b1) begin bad++; $display("FAIL store_owner got %b want 1", o_who[0]); end
    total++; if (o_rdata[0] !== 32'h0) begin bad++; $display("FAIL store_rdata got %h want 0", o_rdata[0]); end
    total++; if (o_lat[0] !== 5) begin bad++; $display("FAIL store_lat got %0d want 5", o_lat[0]); end
    total++; if ({o_addr[0], o_wen[0], o_wdata[0], o_wmask[0]} !== {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin bad++; $display("FAIL store_mem got %h/%b/%h/%b want 80001000/1/deadbeef/0011", o_addr[0], o_wen[0], o_wdata[0], o_wmask[0]); end
    total++; if (o_stable[0] !== 1'b1) begin bad++; $display("FAIL store_stable got %b want 1", o_stable[0]); end
  endtask

  task automatic test_timeout();
    logic [31:0] a;
    logic [31:0] d;
    a = $urandom;
    run_round(1'b1, 1'b0, a, 32'h0, 32'h0, 4'h0, 1'b0, 0, 0, 1'b1, 32'h5555_AAAA, 32'h0);
    m_last = 1'b0;
    // grant N, REQ N+1 (accepted), WAIT N+2..N+2+TO-1, RESP N+2+TO
    total++; if (o_hang[0] !== 1'b0) begin bad++; $display("FAIL tmo_hang got %b want 0", o_hang[0]); end
    total++; if (o_lat[0] !== 2 + TO) begin bad++; $display("FAIL tmo_lat got %0d want %0d", o_lat[0], 2 + TO); end
    total++; if ({o_who[0], o_err[0]} !== 2'b01) begin bad++; $display("FAIL tmo_err got lsu=%b err=%b want 0 1", o_who[0], o_err[0]); end
    total++; if (o_rdata[0] !== 32'h0) begin bad++; $display("FAIL tmo_rdata got %h want 0", o_rdata[0]); end
    d = $urandom;
    run_round(1'b0, 1'b1, 32'h0, a, 32'h0, 4'hF, 1'b0, 0, 0, 1'b0, d, 32'h0);
    m_last = 1'b1;
    total++; if ({o_hang[0], o_who[0], o_err[0]} !== 3'b010) begin bad++; $display("FAIL tmo_next got hang=%b lsu=%b err=%b want 0 1 0", o_hang[0], o_who[0], o_err[0]); end
    total++; if (o_rdata[0] !== d || o_lat[0] !== 2) begin bad++; $display("FAIL tmo_next_data got %h lat %0d want %h lat 2", o_rdata[0], o_lat[0], d); end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    logic [31:0] d;
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0040;
    #1;
    total++; if (bus.ifu_req_ready !== 1'b1) begin bad++; $display("FAIL rw_gnt got %b want 1", bus.ifu_req_ready); end
    @(negedge clk);
    bus.ifu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if ({bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err} !== 5'b0) begin bad++; $display("FAIL rw_ctrl got %b want 00000", {bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err}); end
    total++; if ({bus.mem_addr, bus.ifu_rdata, bus.lsu_rdata} !== 96'h0) begin bad++; $display("FAIL rw_data got %h want 0", {bus.mem_addr, bus.ifu_rdata, bus.lsu_rdata}); end
    @(negedge clk);
    rst    = 1'b0;
    m_last = 1'b0;
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hCAFE_F00D;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (bus.ifu_resp_valid || bus.lsu_resp_valid || bus.mem_req_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rw_late_resp got %0d activity cycles want 0", seen); end
    d = $urandom;
    run_round(1'b1, 1'b0, 32'h8000_0080, 32'h0, 32'h0, 4'h0, 1'b0, 0, 1, 1'b0, d, 32'h0);
    m_last = 1'b0;
    total++; if ({o_hang[0], o_gnt[0], o_who[0]} !== 4'b0010) begin bad++; $display("FAIL rw_next got hang=%b gnt=%b lsu=%b want 0 01 0", o_hang[0], o_gnt[0], o_who[0]); end
    total++; if (o_rdata[0] !== d || o_lat[0] !== 3) begin bad++; $display("FAIL rw_next_data got %h lat %0d want %h lat 3", o_rdata[0], o_lat[0], d); end
  endtask

  // Rounds of random requests (or forced ties) checked against the model.
  task automatic test_rounds(input string tag, input int rounds, input bit force_tie);
    bit ri, rl, wen;
    bit order[2];
    int n, acc, rsp;
    logic [1:0]  r;
    logic [31:0] ia, la, wd, rd0, rd1, rd;
    logic [3:0]  wm;
    logic [33:0] e;
    for (int i = 0; i < rounds; i++) begin
      r   = 2'($urandom_range(1, 3));
      ri  = force_tie ? 1'b1 : r[0];
      rl  = force_tie ? 1'b1 : r[1];
      wen = force_tie ? 1'b0 : 1'($urandom_range(0, 1));
      ia = $urandom; la = $urandom; wd = $urandom; wm = 4'($urandom);
      rd0 = $urandom; rd1 = $urandom;
      acc = $urandom_range(0, 2);
      rsp = $urandom_range(0, 3);
      n = int'(ri) + int'(rl);
      order[0] = model_first(ri, rl);
      order[1] = !order[0];
      m_last   = order[n-1];
      for (int g = 0; g < n; g++) begin
        rd = (g == 0) ? rd0 : rd1;
        exp_q.push_back({order[g], 1'b0, (order[g] && wen) ? 32'h0 : rd});
      end
      run_round(ri, rl, ia, la, wd, wm, wen, acc, rsp, 1'b0, rd0, rd1);
      for (int g = 0; g < n; g++) begin
        e = exp_q.pop_front();
        total++; if (o_hang[g] !== 1'b0) begin bad++; $display("FAIL %s_hang r%0d g%0d got %b want 0", tag, i, g, o_hang[g]); end
        total++; if (o_gnt[g] !== (e[33] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL %s_gnt r%0d g%0d got %b want %b", tag, i, g, o_gnt[g], e[33] ? 2'b10 : 2'b01); end
        total++; if ({o_who[g], o_err[g], o_rdata[g]} !== e) begin bad++; $display("FAIL %s_resp r%0d g%0d got %h want %h", tag, i, g, {o_who[g], o_err[g], o_rdata[g]}, e); end
        total++; if (o_lat[g] !== 2 + acc + rsp) begin bad++; $display("FAIL %s_lat r%0d g%0d got %0d want %0d", tag, i, g, o_lat[g], 2 + acc + rsp); end
        total++; if ({o_leak[g], o_pulse2[g], o_both[g], o_stable[g]} !== 4'b0001) begin bad++; $display("FAIL %s_pulse r%0d g%0d got leak=%b wide=%b both=%b stable=%b", tag, i, g, o_leak[g], o_pulse2[g], o_both[g], o_stable[g]); end
        total++; if (o_addr[g] !== (e[33] ? la : ia)) begin bad++; $display("FAIL %s_addr r%0d g%0d got %h want %h", tag, i, g, o_addr[g], e[33] ? la : ia); end
        total++; if ({o_wen[g], o_wmask[g]} !== (e[33] ? {wen, wm} : 5'b0)) begin bad++; $display("FAIL %s_wen r%0d g%0d got %b want %b", tag, i, g, {o_wen[g], o_wmask[g]}, e[33] ? {wen, wm} : 5'b0); end
        if (e[33]) begin
          total++; if (o_wdata[g] !== wd) begin bad++; $display("FAIL %s_wdata r%0d g%0d got %h want %h", tag, i, g, o_wdata[g], wd); end
        end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ifu_fetch();
    test_store();
    apply_reset();
    test_rounds("tie", 4, 1'b1);
    test_timeout();
    test_reset_in_wait();
    apply_reset();
    test_rounds("rand", 40, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
